// File: rtl/color_event_counter_if.sv
// Sample/clear inputs and registered count/event outputs of the color event counter.
// The bench or sensor-side logic drives through master; the counter itself uses slave.
interface color_event_counter_if;
  logic        sample_valid;
  logic [1:0]  color_code;
  logic        clear;
  logic [11:0] count_r;
  logic [11:0] count_g;
  logic [11:0] count_b;
  logic        event_valid;
  logic [1:0]  event_code;
  logic [2:0]  saturated;

  modport master (
    output sample_valid, color_code, clear,
    input  count_r, count_g, count_b, event_valid, event_code, saturated
  );

  modport slave (
    input  sample_valid, color_code, clear,
    output count_r, count_g, count_b, event_valid, event_code, saturated
  );
endinterface

// File: rtl/color_event_counter.sv
// Debounced per-color object counter: a color must persist STABLE_N valid samples
// to count once, then GAP_N zero samples re-arm; counts are 3-digit packed BCD.
//
// state   | meaning
// ARMED   | waiting for a non-zero sample to start a new object
// QUALIFY | candidate color seen, accumulating identical samples
// COUNTED | object counted, waiting for GAP_N zero samples
module color_event_counter #(
  parameter int STABLE_N = 4,
  parameter int GAP_N    = 2
) (
  input logic                 clk,
  input logic                 rst,
  color_event_counter_if.slave bus
);

  localparam logic [1:0] ARMED   = 2'd0;
  localparam logic [1:0] QUALIFY = 2'd1;
  localparam logic [1:0] COUNTED = 2'd2;

  localparam logic [3:0] STABLE_C = 4'(STABLE_N);
  localparam logic [3:0] GAP_C    = 4'(GAP_N);

  logic [1:0]  state;
  logic [3:0]  run;
  logic [3:0]  gap;
  logic [1:0]  cand;
  logic [11:0] cnt_r, cnt_g, cnt_b;
  logic [2:0]  sat;
  logic        ev_valid;
  logic [1:0]  ev_code;
  logic        hit;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign hit = bus.sample_valid && (state == QUALIFY) &&
               (bus.color_code == cand) && (run + 4'd1 == STABLE_C);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ARMED;
      run   <= 4'd0;
      gap   <= 4'd0;
      cand  <= 2'd0;
    end else if (bus.sample_valid) begin
      case (state)
        ARMED: begin
          if (bus.color_code != 2'd0) begin
            cand  <= bus.color_code;
            run   <= 4'd1;
            state <= QUALIFY;
          end
        end
        QUALIFY: begin
          if (bus.color_code == 2'd0) begin
            run   <= 4'd0;
            state <= ARMED;
          end else if (bus.color_code == cand) begin
            run <= run + 4'd1;
            if (hit) begin
              gap   <= 4'd0;
              state <= COUNTED;
            end
          end else begin
            cand <= bus.color_code;
            run  <= 4'd1;
          end
        end
        COUNTED: begin
          if (bus.color_code == 2'd0) begin
            gap <= gap + 4'd1;
            if (gap + 4'd1 == GAP_C) state <= ARMED;
          end else begin
            gap <= 4'd0;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  // clear outranks a simultaneous count; the event itself is still reported
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= 12'h000;
      cnt_g <= 12'h000;
      cnt_b <= 12'h000;
      sat   <= 3'b000;
    end else if (bus.clear) begin
      cnt_r <= 12'h000;
      cnt_g <= 12'h000;
      cnt_b <= 12'h000;
      sat   <= 3'b000;
    end else if (hit) begin
      case (cand)
        2'd1: begin
          if (cnt_r == 12'h999) sat[0] <= 1'b1;
          cnt_r <= bcd_inc(cnt_r);
        end
        2'd2: begin
          if (cnt_g == 12'h999) sat[1] <= 1'b1;
          cnt_g <= bcd_inc(cnt_g);
        end
        2'd3: begin
          if (cnt_b == 12'h999) sat[2] <= 1'b1;
          cnt_b <= bcd_inc(cnt_b);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ev_valid <= 1'b0;
      ev_code  <= 2'd0;
    end else begin
      ev_valid <= hit;
      if (hit) ev_code <= cand;
    end
  end

  assign bus.count_r     = cnt_r;
  assign bus.count_g     = cnt_g;
  assign bus.count_b     = cnt_b;
  assign bus.saturated   = sat;
  assign bus.event_valid = ev_valid;
  assign bus.event_code  = ev_code;

endmodule

// File: tb/tb_color_event_counter.sv
// Directed bench for color_event_counter with default STABLE_N=4, GAP_N=2.
module tb_color_event_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  color_event_counter_if bus ();

  color_event_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one valid sample held across a single rising edge; returns at the following negedge
  task automatic send(input logic [1:0] code, input logic clr = 1'b0);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.color_code   = code;
    bus.clear        = clr;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.color_code   = 2'd0;
    bus.clear        = 1'b0;
  endtask

  task automatic object(input logic [1:0] code);
    repeat (4) send(code);
    repeat (2) send(2'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cnt_r"}, bus.count_r, 12'h000);
    chk({tag, "_cnt_g"}, bus.count_g, 12'h000);
    chk({tag, "_cnt_b"}, bus.count_b, 12'h000);
    chk({tag, "_ev"},    12'(bus.event_valid), 12'h0);
    chk({tag, "_code"},  12'(bus.event_code), 12'h0);
    chk({tag, "_sat"},   12'(bus.saturated), 12'h0);
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.color_code   = 2'd0;
    bus.clear        = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_reset_state("reset");

    // basic object: event right after the 4th sample
    send(2'd1); chk("b_ev1", 12'(bus.event_valid), 12'h0);
    send(2'd1); chk("b_ev2", 12'(bus.event_valid), 12'h0);
    send(2'd1); chk("b_ev3", 12'(bus.event_valid), 12'h0);
    send(2'd1); chk("b_ev4", 12'(bus.event_valid), 12'h1);
    chk("b_code", 12'(bus.event_code), 12'h1);
    chk("b_cnt_r", bus.count_r, 12'h001);
    send(2'd0); chk("b_ev5", 12'(bus.event_valid), 12'h0);
    send(2'd0); chk("b_ev6", 12'(bus.event_valid), 12'h0);

    // zero aborts the run
    send(2'd1); send(2'd1); send(2'd0);
    send(2'd1); send(2'd1); send(2'd1);
    chk("abort_ev6", 12'(bus.event_valid), 12'h0);
    send(2'd1); chk("abort_ev7", 12'(bus.event_valid), 12'h1);
    chk("abort_cnt_r", bus.count_r, 12'h002);
    send(2'd0); send(2'd0);

    // candidate switch
    send(2'd2); send(2'd2); send(2'd3); send(2'd3); send(2'd3);
    chk("sw_ev5", 12'(bus.event_valid), 12'h0);
    send(2'd3); chk("sw_ev6", 12'(bus.event_valid), 12'h1);
    chk("sw_code", 12'(bus.event_code), 12'h3);
    chk("sw_cnt_b", bus.count_b, 12'h001);
    chk("sw_cnt_g", bus.count_g, 12'h000);

    // short gap must not re-arm
    send(2'd3); send(2'd3); send(2'd3); send(2'd0);
    send(2'd3); chk("gap_ev", 12'(bus.event_valid), 12'h0);
    chk("gap_cnt_b", bus.count_b, 12'h001);
    send(2'd0); send(2'd0);
    send(2'd3); send(2'd3); send(2'd3);
    send(2'd3); chk("gap_ev2", 12'(bus.event_valid), 12'h1);
    chk("gap_cnt_b2", bus.count_b, 12'h002);
    send(2'd0); send(2'd0);

    // idle cycles without sample_valid hold the FSM
    send(2'd1); send(2'd1); send(2'd1);
    repeat (5) @(negedge clk);
    send(2'd1); chk("hold_ev", 12'(bus.event_valid), 12'h1);
    chk("hold_cnt_r", bus.count_r, 12'h003);
    send(2'd0); send(2'd0);

    // BCD carries and saturation on green
    for (int i = 0; i < 9; i++) object(2'd2);
    chk("bcd_009", bus.count_g, 12'h009);
    object(2'd2);
    chk("bcd_010", bus.count_g, 12'h010);
    for (int i = 0; i < 89; i++) object(2'd2);
    chk("bcd_099", bus.count_g, 12'h099);
    object(2'd2);
    chk("bcd_100", bus.count_g, 12'h100);
    for (int i = 0; i < 899; i++) object(2'd2);
    chk("bcd_999", bus.count_g, 12'h999);
    repeat (3) send(2'd2);
    send(2'd2); chk("sat_ev", 12'(bus.event_valid), 12'h1);
    chk("sat_cnt_g", bus.count_g, 12'h999);
    chk("sat_bits", 12'(bus.saturated), 12'h002);
    send(2'd0); send(2'd0);

    // clear coincident with a count
    send(2'd1); send(2'd1); send(2'd1);
    send(2'd1, 1'b1);
    chk("clr_ev", 12'(bus.event_valid), 12'h1);
    chk("clr_code", 12'(bus.event_code), 12'h1);
    chk("clr_cnt_r", bus.count_r, 12'h000);
    chk("clr_cnt_g", bus.count_g, 12'h000);
    chk("clr_cnt_b", bus.count_b, 12'h000);
    chk("clr_sat", 12'(bus.saturated), 12'h0);
    send(2'd0); send(2'd0);

    // reset mid-QUALIFY abandons the object
    send(2'd1); send(2'd1); send(2'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk_reset_state("rstq");
    send(2'd1); chk("rstq_ev1", 12'(bus.event_valid), 12'h0);
    send(2'd1); chk("rstq_ev2", 12'(bus.event_valid), 12'h0);
    chk("rstq_cnt_r", bus.count_r, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
